// File: rtl/ahb_slave_mux_if.sv
// AHB slave-side bus bundle between the address decoder, the slaves and the read-data mux.
interface ahb_slave_mux_if #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned NO_OF_SLAVES = 2
);
    logic [NO_OF_SLAVES-1:0]            HSEL;
    logic [1:0]                         HTRANS;
    logic [NO_OF_SLAVES*DATA_WIDTH-1:0] HRDATA_S;
    logic [NO_OF_SLAVES-1:0]            HREADYOUT_S;
    logic [NO_OF_SLAVES-1:0]            HRESP_S;
    logic [DATA_WIDTH-1:0]              HRDATA;
    logic                               HREADY;
    logic                               HRESP;

    // Decoder/slave side: drives selects and slave responses, sees the muxed result.
    modport master (
        output HSEL, HTRANS, HRDATA_S, HREADYOUT_S, HRESP_S,
        input  HRDATA, HREADY, HRESP
    );

    // Mux side.
    modport slave (
        input  HSEL, HTRANS, HRDATA_S, HREADYOUT_S, HRESP_S,
        output HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/ahb_slave_mux.sv
// AHB slave-to-master response mux with a built-in default slave for unmapped addresses.
module ahb_slave_mux #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned NO_OF_SLAVES = 2
) (
    input  logic            HCLK,
    input  logic            HRESET,
    ahb_slave_mux_if.slave  bus
);
    localparam int unsigned DW = DATA_WIDTH;
    localparam int unsigned NS = NO_OF_SLAVES;

    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;

    typedef enum logic [1:0] {
        D_IDLE = 2'b00,
        D_ERR1 = 2'b01,
        D_ERR2 = 2'b10
    } dflt_state_e;

    dflt_state_e   state_q, state_d;
    logic [NS-1:0] dp_sel_q, dp_sel_d;
    logic [NS-1:0] hsel_low;
    logic          unmapped_xfer;

    logic [DW-1:0] hrdata_c;
    logic          hready_c;
    logic          hresp_c;

    // Isolate the lowest set select bit so a multi-hot decode still picks one slave.
    assign hsel_low = bus.HSEL & (~bus.HSEL + NS'(1));

    // An active transfer accepted with no slave selected goes to the default slave.
    assign unmapped_xfer = hready_c && (bus.HSEL == '0) &&
                           ((bus.HTRANS == TRANS_NONSEQ) || (bus.HTRANS == TRANS_SEQ));

    // Data-phase select advances only when the current data phase completes.
    assign dp_sel_d = hready_c ? hsel_low : dp_sel_q;

    // Data-phase select and default-slave state registers.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            dp_sel_q <= '0;
            state_q  <= D_IDLE;
        end else begin
            dp_sel_q <= dp_sel_d;
            state_q  <= state_d;
        end
    end

    // Default-slave two-cycle ERROR sequence.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            D_IDLE:  if (unmapped_xfer) state_d = D_ERR1;
            D_ERR1:  state_d = D_ERR2;
            D_ERR2:  state_d = unmapped_xfer ? D_ERR1 : D_IDLE;
            default: state_d = D_IDLE;
        endcase
    end

    // Response mux; only the selected slave's lane is ever read so unselected X cannot leak.
    always_comb begin
        hrdata_c = '0;
        hready_c = 1'b1;
        hresp_c  = 1'b0;
        if (state_q == D_ERR1) begin
            hready_c = 1'b0;
            hresp_c  = 1'b1;
        end else if (state_q == D_ERR2) begin
            hready_c = 1'b1;
            hresp_c  = 1'b1;
        end else begin
            for (int i = 0; i < int'(NS); i++) begin
                if (dp_sel_q[i]) begin
                    hrdata_c = bus.HRDATA_S[i*int'(DW) +: DW];
                    hready_c = bus.HREADYOUT_S[i];
                    hresp_c  = bus.HRESP_S[i];
                end
            end
        end
    end

    assign bus.HRDATA = hrdata_c;
    assign bus.HREADY = hready_c;
    assign bus.HRESP  = hresp_c;

endmodule

// File: tb/tb_ahb_slave_mux.sv
// Directed self-checking bench for ahb_slave_mux (2 slaves, 32-bit data).
module tb_ahb_slave_mux;
    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] BUSY   = 2'b01;
    localparam logic [1:0] NONSEQ = 2'b10;
    localparam logic [1:0] SEQ    = 2'b11;

    // {HREADY, HRESP, HRDATA} reference patterns
    localparam logic [33:0] OKAY0 = 34'h2_0000_0000;
    localparam logic [33:0] ERR1  = 34'h1_0000_0000;
    localparam logic [33:0] ERR2  = 34'h3_0000_0000;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    ahb_slave_mux_if #(.DATA_WIDTH(32), .NO_OF_SLAVES(2)) bus ();

    ahb_slave_mux #(.DATA_WIDTH(32), .NO_OF_SLAVES(2)) dut (
        .HCLK   (clk),
        .HRESET (rst),
        .bus    (bus)
    );

    wire logic [33:0] obs = {bus.HREADY, bus.HRESP, bus.HRDATA};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        bus.HSEL        = 2'b00;
        bus.HTRANS      = IDLE;
        bus.HREADYOUT_S = 2'b11;
        bus.HRESP_S     = 2'b00;
        bus.HRDATA_S    = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            bus.HSEL        = 2'b01;
            bus.HTRANS      = NONSEQ;
            bus.HRDATA_S    = {$urandom, $urandom};
            bus.HREADYOUT_S = 2'(c);
            bus.HRESP_S     = 2'(c + 1);
            tick();
            n_checks++;
            if (obs !== OKAY0) begin
                n_fail++;
                $display("FAIL reset_hold_%0d: got %h required %h", c, obs, OKAY0);
            end
        end
        idle_bus();
        rst = 1'b0;
        #1;
        n_checks++;
        if (obs !== OKAY0) begin
            n_fail++;
            $display("FAIL reset_release: got %h required %h", obs, OKAY0);
        end
    endtask

    task automatic test_zero_wait();
        bus.HSEL     = 2'b10;
        bus.HTRANS   = NONSEQ;
        bus.HRDATA_S = {32'hCAFE_0001, 32'h0000_BEEF};
        #1;
        n_checks++;
        if (obs !== OKAY0) begin
            n_fail++;
            $display("FAIL zw_addr_phase: got %h required %h", obs, OKAY0);
        end
        tick();
        bus.HSEL   = 2'b00;
        bus.HTRANS = IDLE;
        #1;
        n_checks++;
        if (obs !== 34'h2_CAFE_0001) begin
            n_fail++;
            $display("FAIL zw_data_s1: got %h required %h", obs, 34'h2_CAFE_0001);
        end
        bus.HRESP_S     = 2'b10;
        bus.HREADYOUT_S = 2'b10;
        #1;
        n_checks++;
        if (obs !== 34'h3_CAFE_0001) begin
            n_fail++;
            $display("FAIL zw_resp_pass: got %h required %h", obs, 34'h3_CAFE_0001);
        end
        tick();
        #1;
        n_checks++;
        if (obs !== OKAY0) begin
            n_fail++;
            $display("FAIL zw_after: got %h required %h", obs, OKAY0);
        end
        idle_bus();
    endtask

    task automatic test_wait_state();
        bus.HSEL     = 2'b01;
        bus.HTRANS   = NONSEQ;
        bus.HRDATA_S = {32'h1111_1111, 32'h0000_0A0A};
        tick();
        bus.HREADYOUT_S = 2'bx0;
        bus.HRESP_S     = 2'bx0;
        bus.HSEL        = 2'b10;
        bus.HTRANS      = NONSEQ;
        #1;
        n_checks++;
        if (obs !== 34'h0_0000_0A0A) begin
            n_fail++;
            $display("FAIL ws_wait1: got %h required %h", obs, 34'h0_0000_0A0A);
        end
        tick();
        n_checks++;
        if (obs !== 34'h0_0000_0A0A) begin
            n_fail++;
            $display("FAIL ws_wait2_hold: got %h required %h", obs, 34'h0_0000_0A0A);
        end
        tick();
        bus.HREADYOUT_S = 2'bx1;
        #1;
        n_checks++;
        if (obs !== 34'h2_0000_0A0A) begin
            n_fail++;
            $display("FAIL ws_done: got %h required %h", obs, 34'h2_0000_0A0A);
        end
        tick();
        bus.HREADYOUT_S = 2'b11;
        bus.HRESP_S     = 2'b00;
        bus.HSEL        = 2'b00;
        bus.HTRANS      = IDLE;
        #1;
        n_checks++;
        if (obs !== 34'h2_1111_1111) begin
            n_fail++;
            $display("FAIL ws_b2b_s1: got %h required %h", obs, 34'h2_1111_1111);
        end
        tick();
        n_checks++;
        if (obs !== OKAY0) begin
            n_fail++;
            $display("FAIL ws_after: got %h required %h", obs, OKAY0);
        end
        idle_bus();
    endtask

    task automatic test_multi_hot();
        bus.HSEL     = 2'b11;
        bus.HTRANS   = NONSEQ;
        bus.HRDATA_S = {32'h2222_2222, 32'h3333_3333};
        tick();
        bus.HSEL   = 2'b00;
        bus.HTRANS = IDLE;
        #1;
        n_checks++;
        if (obs !== 34'h2_3333_3333) begin
            n_fail++;
            $display("FAIL mh_lowest: got %h required %h", obs, 34'h2_3333_3333);
        end
        tick();
        n_checks++;
        if (obs !== OKAY0) begin
            n_fail++;
            $display("FAIL mh_after: got %h required %h", obs, OKAY0);
        end
        idle_bus();
    endtask

    task automatic test_unmapped();
        bus.HSEL   = 2'b00;
        bus.HTRANS = NONSEQ;
        #1;
        n_checks++;
        if (obs !== OKAY0) begin
            n_fail++;
            $display("FAIL um_addr: got %h required %h", obs, OKAY0);
        end
        tick();
        bus.HTRANS = IDLE;
        #1;
        n_checks++;
        if (obs !== ERR1) begin
            n_fail++;
            $display("FAIL um_err1: got %h required %h", obs, ERR1);
        end
        tick();
        n_checks++;
        if (obs !== ERR2) begin
            n_fail++;
            $display("FAIL um_err2: got %h required %h", obs, ERR2);
        end
        tick();
        n_checks++;
        if (obs !== OKAY0) begin
            n_fail++;
            $display("FAIL um_okay: got %h required %h", obs, OKAY0);
        end
    endtask

    task automatic test_back_to_back();
        bus.HSEL   = 2'b00;
        bus.HTRANS = BUSY;
        tick();
        bus.HTRANS = NONSEQ;
        #1;
        n_checks++;
        if (obs !== OKAY0) begin
            n_fail++;
            $display("FAIL b2b_busy_okay: got %h required %h", obs, OKAY0);
        end
        tick();
        bus.HTRANS = SEQ;
        #1;
        n_checks++;
        if (obs !== ERR1) begin
            n_fail++;
            $display("FAIL b2b_err1_a: got %h required %h", obs, ERR1);
        end
        tick();
        n_checks++;
        if (obs !== ERR2) begin
            n_fail++;
            $display("FAIL b2b_err2_a: got %h required %h", obs, ERR2);
        end
        tick();
        bus.HTRANS = IDLE;
        #1;
        n_checks++;
        if (obs !== ERR1) begin
            n_fail++;
            $display("FAIL b2b_err1_b: got %h required %h", obs, ERR1);
        end
        tick();
        n_checks++;
        if (obs !== ERR2) begin
            n_fail++;
            $display("FAIL b2b_err2_b: got %h required %h", obs, ERR2);
        end
        tick();
        n_checks++;
        if (obs !== OKAY0) begin
            n_fail++;
            $display("FAIL b2b_okay: got %h required %h", obs, OKAY0);
        end
    endtask

    task automatic test_reset_mid_err();
        bus.HSEL   = 2'b00;
        bus.HTRANS = NONSEQ;
        tick();
        bus.HTRANS = IDLE;
        #1;
        n_checks++;
        if (obs !== ERR1) begin
            n_fail++;
            $display("FAIL rme_err1: got %h required %h", obs, ERR1);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (obs !== OKAY0) begin
            n_fail++;
            $display("FAIL rme_async: got %h required %h", obs, OKAY0);
        end
        tick();
        rst          = 1'b0;
        bus.HSEL     = 2'b01;
        bus.HTRANS   = NONSEQ;
        bus.HRDATA_S = {32'hFFFF_0000, 32'h5A5A_C3C3};
        #1;
        n_checks++;
        if (obs !== OKAY0) begin
            n_fail++;
            $display("FAIL rme_released: got %h required %h", obs, OKAY0);
        end
        tick();
        bus.HSEL   = 2'b00;
        bus.HTRANS = IDLE;
        #1;
        n_checks++;
        if (obs !== 34'h2_5A5A_C3C3) begin
            n_fail++;
            $display("FAIL rme_s0_data: got %h required %h", obs, 34'h2_5A5A_C3C3);
        end
        tick();
        n_checks++;
        if (obs !== OKAY0) begin
            n_fail++;
            $display("FAIL rme_after: got %h required %h", obs, OKAY0);
        end
        idle_bus();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        idle_bus();
        test_reset();
        test_zero_wait();
        test_wait_state();
        test_multi_hot();
        test_unmapped();
        test_back_to_back();
        test_reset_mid_err();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb_slave_mux.md
AHB_SLAVE_MUX -- requirements
Module: ahb_slave_mux

Interface
- REQ-001: Parameter DATA_WIDTH, default 32, is the width of HRDATA and of each slave read-data lane.
- REQ-002: Parameter NO_OF_SLAVES, default 2, is the number of slave ports (1..9), matching the HSEL width produced by the address decoder.
- REQ-003: HCLK  input  1  single bus clock; all state changes occur on its rising edge.
- REQ-004: HRESET  input  1  asynchronous, active-high reset.
- REQ-005: HSEL  input  NO_OF_SLAVES  one-hot address-phase slave select from the decoder.
- REQ-006: HTRANS  input  2  address-phase transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
- REQ-007: HRDATA_S  input  NO_OF_SLAVES*DATA_WIDTH  concatenated slave read data; slave i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- REQ-008: HREADYOUT_S  input  NO_OF_SLAVES  per-slave ready; bit i belongs to slave i.
- REQ-009: HRESP_S  input  NO_OF_SLAVES  per-slave response (0 OKAY, 1 ERROR); bit i belongs to slave i.
- REQ-010: HRDATA  output  DATA_WIDTH  read data returned to the master.
- REQ-011: HREADY  output  1  transfer-done signal to the master; it is also broadcast to all slaves as their HREADY input.
- REQ-012: HRESP  output  1  response returned to the master.

Function
- REQ-013: The block SHALL register HSEL into a data-phase select register (dp_sel) on every rising HCLK edge where HREADY is 1, and SHALL hold dp_sel unchanged while HREADY is 0.
- REQ-014: When HSEL is multi-hot, the block SHALL store only the lowest-index set bit into dp_sel.
- REQ-015: When dp_sel bit i is set, HRDATA, HREADY and HRESP SHALL equal slave i's lane, HREADYOUT_S[i] and HRESP_S[i] combinationally, with zero added latency.
- REQ-016: The block SHALL contain a default-slave FSM with states D_IDLE, D_ERR1 and D_ERR2.
- REQ-017: The FSM SHALL go from D_IDLE or D_ERR2 to D_ERR1 on an edge where HREADY=1, HSEL is all zero and HTRANS[1]=1 (NONSEQ or SEQ).
- REQ-018: The FSM SHALL go from D_ERR1 to D_ERR2 unconditionally on the next edge.
- REQ-019: The FSM SHALL go from D_ERR2 to D_IDLE on the next edge unless the condition in REQ-017 holds on that edge.
- REQ-020: While the FSM is in D_ERR1, the outputs SHALL be HREADY=0, HRESP=1 and HRDATA=0.
- REQ-021: While the FSM is in D_ERR2, the outputs SHALL be HREADY=1, HRESP=1 and HRDATA=0.
- REQ-022: When dp_sel is zero and the FSM is in D_IDLE (IDLE or BUSY transfer, or unmapped IDLE/BUSY), the outputs SHALL be HREADY=1, HRESP=0 and HRDATA=0, i.e. an OKAY response with no wait states.
- REQ-023: Any new address phase sampled while a slave data phase is active SHALL not take effect until that slave's HREADYOUT_S is 1.
- REQ-024: Back-to-back transfers SHALL be supported; a new address phase is accepted in the same cycle that the previous data phase completes.
- REQ-025: The block SHALL produce no X on any output when an HREADYOUT_S or HRESP_S input of an unselected slave is X.

Reset
- REQ-026: While HRESET=1, the block SHALL immediately clear dp_sel to zero and force the FSM to D_IDLE, regardless of HCLK.
- REQ-027: As a result of REQ-026, the outputs during and directly after reset SHALL be HREADY=1, HRESP=0 and HRDATA=0.
- REQ-028: Asserting reset in the middle of a wait-stated slave transfer or an ERROR sequence SHALL abort it, with no residual state after release.
- REQ-029: The first edge after reset is deasserted SHALL sample an address phase normally.

Verification
- REQ-030: Reset check: hold HRESET=1 for 3 cycles while slave inputs toggle -> HREADY=1, HRESP=0, HRDATA=0 throughout.
- REQ-031: Zero-wait read from slave 1: HSEL=2'b10, HTRANS=10, HRDATA_S[63:32]=32'hCAFE_0001 -> next cycle HRDATA=32'hCAFE_0001, HREADY=1, HRESP=0.
- REQ-032: Wait-stated read: slave 0 holds HREADYOUT_S[0]=0 for 2 cycles while a new address phase with HSEL=2'b10 is presented -> HREADY=0 for 2 cycles, dp_sel stays 2'b01, and slave 1 is selected only after HREADY=1.
- REQ-033: Unmapped NONSEQ: HSEL=0, HTRANS=10 -> cycle+1 HREADY=0/HRESP=1, cycle+2 HREADY=1/HRESP=1, cycle+3 OKAY.
- REQ-034: Unmapped BUSY then back-to-back unmapped SEQ issued during D_ERR2 -> BUSY gets zero-wait OKAY; the FSM passes D_ERR2 -> D_ERR1 directly with no OKAY cycle in between.
- REQ-035: Reset asserted asynchronously mid-D_ERR1 -> outputs are HREADY=1/HRESP=0 before the next HCLK edge; after release a slave-0 transfer completes normally.
